// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the UART TX FIFO.
// The requester/UART side uses the master modport and the arbiter uses the slave modport.
interface uart_tx_arb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   last;
    logic [8*NREQ-1:0] data;
    logic [NREQ-1:0]   ack;
    logic [NREQ-1:0]   gnt;
    logic              tx_full;
    logic              wr_uart;
    logic [7:0]        w_data;
    logic              busy;
    logic              abort_tick;

    modport master (
        output req, last, data, tx_full,
        input  ack, gnt, wr_uart, w_data, busy, abort_tick
    );

    modport slave (
        input  req, last, data, tx_full,
        output ack, gnt, wr_uart, w_data, busy, abort_tick
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Packet-granular round-robin arbiter that shares one UART TX path among NREQ requesters.
// Define UART_TX_ARB_TIMEOUT_EN to drop a grant whose owner has stalled for TIMEOUT cycles.
module uart_tx_arb #(
    parameter int NREQ     = 4,
    parameter int NREQ_BIT = 2,
    parameter int TIMEOUT  = 1024,
    parameter int TO_BIT   = 11
) (
    input  logic         clk,
    input  logic         reset,
    uart_tx_arb_if.slave bus
);
    typedef enum logic {IDLE, XFER} state_e;

    state_e              state_q, state_d;
    logic [NREQ_BIT-1:0] g_q, g_d;
    logic [NREQ_BIT-1:0] p_q, p_d;
    logic [NREQ_BIT-1:0] pick;
    logic                any_req;
    logic                acc;
    logic                to_hit;

    logic [NREQ-1:0]     ack_c;
    logic [NREQ-1:0]     gnt_c;
    logic [7:0]          wdat_c;

    // First requesting index after the last-served pointer, wrapping.
    always_comb begin : pick_scan
        int  k;
        logic found;
        pick  = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= NREQ; i++) begin
            k = int'(p_q) + i;
            if (k >= NREQ) k = k - NREQ;
            if (!found && bus.req[k]) begin
                found = 1'b1;
                pick  = NREQ_BIT'(k);
            end
        end
    end

    assign any_req = |bus.req;
    assign acc     = (state_q == XFER) && bus.req[g_q] && !bus.tx_full;

`ifdef UART_TX_ARB_TIMEOUT_EN
    logic [TO_BIT-1:0] cnt_q, cnt_d;

    assign to_hit = (state_q == XFER) && !bus.req[g_q]
                    && (cnt_q == TO_BIT'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == IDLE || bus.req[g_q]) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= NREQ_BIT'(NREQ - 1);
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = XFER;
                    g_d     = pick;
                end
            end
            XFER: begin
                if ((acc && bus.last[g_q]) || to_hit) begin
                    state_d = IDLE;
                    p_d     = g_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from state so reset clears them immediately.
    always_comb begin
        ack_c  = '0;
        gnt_c  = '0;
        wdat_c = 8'h00;
        if (state_q == XFER) begin
            gnt_c[g_q] = 1'b1;
            ack_c[g_q] = acc;
        end
        if (acc) wdat_c = bus.data[int'(g_q)*8 +: 8];
    end

    assign bus.ack        = ack_c;
    assign bus.gnt        = gnt_c;
    assign bus.wr_uart    = acc;
    assign bus.w_data     = wdat_c;
    assign bus.busy       = (state_q == XFER);
    assign bus.abort_tick = to_hit;
endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed self-checking bench for uart_tx_arb with four requesters.
// Requesters advance to their next byte on the edge after seeing their ack.
module tb_uart_tx_arb;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    uart_tx_arb_if #(.NREQ(NREQ)) bus ();

    uart_tx_arb #(
        .NREQ(NREQ), .NREQ_BIT(2), .TIMEOUT(16), .TO_BIT(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    int errs = 0;
    int checks = 0;

    logic [7:0] pd [NREQ][16];
    logic       pl [NREQ][16];
    int         plen [NREQ];
    int         pidx [NREQ];
    logic       hold [NREQ];
    logic [7:0] wlog [$];

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            if (pidx[i] < plen[i]) begin
                bus.req[i]         = !hold[i];
                bus.last[i]        = pl[i][pidx[i]];
                bus.data[8*i +: 8] = pd[i][pidx[i]];
            end else begin
                bus.req[i]         = 1'b0;
                bus.last[i]        = 1'b0;
                bus.data[8*i +: 8] = 8'h00;
            end
        end
    endtask

    task automatic add_byte(input int r, input logic [7:0] b, input logic l);
        pd[r][plen[r]] = b;
        pl[r][plen[r]] = l;
        plen[r]++;
    endtask

    task automatic clear_model();
        for (int i = 0; i < NREQ; i++) begin
            plen[i] = 0;
            pidx[i] = 0;
            hold[i] = 1'b0;
        end
        wlog.delete();
        drive();
    endtask

    // Called mid-cycle; checks invariants, logs the write, advances one clock.
    task automatic tick();
        logic [NREQ-1:0] a;
        checks++;
        if (((bus.ack & ~bus.gnt) != 0) || (bus.wr_uart !== (|bus.ack))
            || ($countones(bus.gnt) > 1)) begin
            errs++;
            $display("FAIL ack_vs_gnt: ack=%b gnt=%b wr=%b", bus.ack, bus.gnt, bus.wr_uart);
        end
        checks++;
        if (!bus.wr_uart && bus.w_data !== 8'h00) begin
            errs++;
            $display("FAIL wdata_idle: got %h want 00", bus.w_data);
        end
        a = bus.ack;
        if (bus.wr_uart) wlog.push_back(bus.w_data);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) if (a[i]) pidx[i]++;
        drive();
        #4;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.tx_full = 1'b0;
        clear_model();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #4;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.tx_full = 1'b0;
        clear_model();
        #12;
        checks++;
        if ({bus.gnt, bus.ack, bus.wr_uart, bus.w_data, bus.busy, bus.abort_tick} !== '0) begin
            errs++;
            $display("FAIL reset_outputs: gnt=%b ack=%b wr=%b wd=%h busy=%b abort=%b want all 0",
                     bus.gnt, bus.ack, bus.wr_uart, bus.w_data, bus.busy, bus.abort_tick);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #4;
        tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0) begin
            errs++;
            $display("FAIL idle_no_req: gnt=%b busy=%b want 0000 0", bus.gnt, bus.busy);
        end
    endtask

    task automatic test_single();
        do_reset();
        add_byte(2, 8'h41, 1'b0);
        add_byte(2, 8'h42, 1'b0);
        add_byte(2, 8'h43, 1'b1);
        drive();
        #1;
        checks++;
        if (bus.gnt !== 4'b0000 || bus.wr_uart !== 1'b0) begin
            errs++;
            $display("FAIL single_idle: gnt=%b wr=%b want 0000 0", bus.gnt, bus.wr_uart);
        end
        tick();
        checks++;
        if ({bus.gnt, bus.busy, bus.wr_uart, bus.w_data, bus.ack} !== {4'b0100, 1'b1, 1'b1, 8'h41, 4'b0100}) begin
            errs++;
            $display("FAIL single_b1: gnt=%b busy=%b wr=%b wd=%h ack=%b want 0100 1 1 41 0100",
                     bus.gnt, bus.busy, bus.wr_uart, bus.w_data, bus.ack);
        end
        tick();
        checks++;
        if (bus.wr_uart !== 1'b1 || bus.w_data !== 8'h42) begin
            errs++;
            $display("FAIL single_b2: wr=%b wd=%h want 1 42", bus.wr_uart, bus.w_data);
        end
        tick();
        checks++;
        if (bus.wr_uart !== 1'b1 || bus.w_data !== 8'h43 || bus.ack !== 4'b0100) begin
            errs++;
            $display("FAIL single_b3: wr=%b wd=%h ack=%b want 1 43 0100", bus.wr_uart, bus.w_data, bus.ack);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.busy !== 1'b0 || bus.wr_uart !== 1'b0) begin
            errs++;
            $display("FAIL single_end: gnt=%b busy=%b wr=%b want 0000 0 0", bus.gnt, bus.busy, bus.wr_uart);
        end
    endtask

    task automatic test_round_robin();
        logic [7:0]      exp_b [10];
        logic [19:0]     wmask;
        logic [NREQ-1:0] garr [20];
        exp_b = '{8'hA0, 8'hA1, 8'hB0, 8'hB1, 8'hC0, 8'hC1, 8'hD0, 8'hD1, 8'hA2, 8'hA3};
        do_reset();
        add_byte(0, 8'hA0, 1'b0); add_byte(0, 8'hA1, 1'b1);
        add_byte(0, 8'hA2, 1'b0); add_byte(0, 8'hA3, 1'b1);
        add_byte(1, 8'hB0, 1'b0); add_byte(1, 8'hB1, 1'b1);
        add_byte(2, 8'hC0, 1'b0); add_byte(2, 8'hC1, 1'b1);
        add_byte(3, 8'hD0, 1'b0); add_byte(3, 8'hD1, 1'b1);
        drive();
        #1;
        wmask = '0;
        for (int c = 0; c < 20; c++) begin
            wmask[c] = bus.wr_uart;
            garr[c]  = bus.gnt;
            tick();
        end
        checks++;
        if (wmask !== 20'h06DB6) begin
            errs++;
            $display("FAIL rr_timing: write cycles=%h want 06db6", wmask);
        end
        checks++;
        if ({garr[1], garr[3], garr[4], garr[7], garr[10], garr[13]}
            !== {4'b0001, 4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0001}) begin
            errs++;
            $display("FAIL rr_order: gnt@1,3,4,7,10,13=%b %b %b %b %b %b want 0001 0000 0010 0100 1000 0001",
                     garr[1], garr[3], garr[4], garr[7], garr[10], garr[13]);
        end
        checks++;
        if (wlog.size() != 10) begin
            errs++;
            $display("FAIL rr_count: got %0d bytes want 10", wlog.size());
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (wlog[i] !== exp_b[i]) begin
                    errs++;
                    $display("FAIL rr_byte%0d: got %h want %h", i, wlog[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_tx_full();
        int bad;
        clear_model();
        add_byte(1, 8'h51, 1'b0);
        add_byte(1, 8'h52, 1'b0);
        add_byte(1, 8'h53, 1'b1);
        drive();
        #1;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.w_data !== 8'h51) begin
            errs++;
            $display("FAIL full_first: gnt=%b wd=%h want 0010 51", bus.gnt, bus.w_data);
        end
        tick();
        bus.tx_full = 1'b1;
        #1;
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            if (bus.wr_uart || bus.ack != 0 || bus.abort_tick || bus.gnt != 4'b0010) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL full_stall: %0d bad cycles want 0", bad);
        end
        bus.tx_full = 1'b0;
        #1;
        checks++;
        if (bus.wr_uart !== 1'b1 || bus.w_data !== 8'h52 || bus.ack !== 4'b0010) begin
            errs++;
            $display("FAIL full_resume: wr=%b wd=%h ack=%b want 1 52 0010", bus.wr_uart, bus.w_data, bus.ack);
        end
        tick();
        checks++;
        if (bus.w_data !== 8'h53) begin
            errs++;
            $display("FAIL full_last: wd=%h want 53", bus.w_data);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0000) begin
            errs++;
            $display("FAIL full_end: gnt=%b want 0000", bus.gnt);
        end
    endtask

    task automatic test_pause();
        int bad;
        logic [7:0] exp_b [6];
        exp_b = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h72};
        do_reset();
        for (int i = 0; i < 4; i++) add_byte(1, 8'(8'h61 + i), (i == 3));
        add_byte(3, 8'h71, 1'b0);
        add_byte(3, 8'h72, 1'b1);
        drive();
        #1;
        tick();
        checks++;
        if (bus.gnt !== 4'b0010 || bus.w_data !== 8'h61) begin
            errs++;
            $display("FAIL pause_grant: gnt=%b wd=%h want 0010 61", bus.gnt, bus.w_data);
        end
        tick();
        hold[1] = 1'b1;
        drive();
        #1;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.gnt != 4'b0010 || bus.wr_uart || !bus.busy) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL pause_hold: %0d bad cycles want 0", bad);
        end
        hold[1] = 1'b0;
        drive();
        #1;
        checks++;
        if (bus.wr_uart !== 1'b1 || bus.w_data !== 8'h62) begin
            errs++;
            $display("FAIL pause_resume: wr=%b wd=%h want 1 62", bus.wr_uart, bus.w_data);
        end
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (wlog.size() != 6) begin
            errs++;
            $display("FAIL pause_count: got %0d bytes want 6", wlog.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (wlog[i] !== exp_b[i]) begin
                    errs++;
                    $display("FAIL pause_byte%0d: got %h want %h", i, wlog[i], exp_b[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) add_byte(2, 8'(8'h81 + i), (i == 4));
        drive();
        #1;
        tick();
        tick();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.w_data !== 8'h82) begin
            errs++;
            $display("FAIL rmid_b2: gnt=%b wd=%h want 0100 82", bus.gnt, bus.w_data);
        end
        add_byte(0, 8'h91, 1'b1);
        drive();
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.ack, bus.wr_uart, bus.w_data, bus.busy, bus.abort_tick} !== '0) begin
            errs++;
            $display("FAIL rmid_async: gnt=%b ack=%b wr=%b wd=%h busy=%b abort=%b want all 0",
                     bus.gnt, bus.ack, bus.wr_uart, bus.w_data, bus.busy, bus.abort_tick);
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #4;
        tick();
        checks++;
        if (bus.gnt !== 4'b0001 || bus.w_data !== 8'h91) begin
            errs++;
            $display("FAIL rmid_prio: gnt=%b wd=%h want 0001 91", bus.gnt, bus.w_data);
        end
        tick();
        tick();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.w_data !== 8'h82) begin
            errs++;
            $display("FAIL rmid_retry: gnt=%b wd=%h want 0100 82", bus.gnt, bus.w_data);
        end
    endtask

`ifdef UART_TX_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int bad;
        do_reset();
        add_byte(1, 8'hE1, 1'b0);
        add_byte(1, 8'hE2, 1'b0);
        add_byte(1, 8'hE3, 1'b1);
        drive();
        #1;
        tick();
        tick();
        hold[1] = 1'b1;
        add_byte(2, 8'hF0, 1'b1);
        drive();
        #1;
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (bus.abort_tick || bus.gnt != 4'b0010) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errs++;
            $display("FAIL to_early: %0d bad cycles want 0", bad);
        end
        checks++;
        if (bus.abort_tick !== 1'b1) begin
            errs++;
            $display("FAIL to_pulse: abort=%b want 1", bus.abort_tick);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0000 || bus.abort_tick !== 1'b0) begin
            errs++;
            $display("FAIL to_idle: gnt=%b abort=%b want 0000 0", bus.gnt, bus.abort_tick);
        end
        tick();
        checks++;
        if (bus.gnt !== 4'b0100 || bus.w_data !== 8'hF0) begin
            errs++;
            $display("FAIL to_next: gnt=%b wd=%h want 0100 f0", bus.gnt, bus.w_data);
        end
        clear_model();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_tx_full();
        test_pause();
        test_reset_mid();
`ifdef UART_TX_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
